// File: rtl/disp7seg_scan.sv
// Time-multiplexed common-anode 7-segment scanner with double-buffered load,
// per-digit decimal points, leading-zero blanking, PWM brightness and an
// anti-ghosting guard band. Define DISP7SEG_HEX_DECODE_EN to show A..F for
// digit values 10..15; otherwise those values are shown blank.
module disp7seg_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 100000,
    parameter int BRIGHT_W   = 3,
    parameter int GUARD      = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [4*NUM_DIGITS-1:0]       digits_i,
    input  logic [NUM_DIGITS-1:0]         dp_i,
    input  logic                          load_i,
    input  logic [BRIGHT_W-1:0]           bright_i,
    input  logic                          lz_blank_i,
    output logic [NUM_DIGITS-1:0]         enabled,
    output logic [6:0]                    ag,
    output logic                          dp,
    output logic [$clog2(NUM_DIGITS)-1:0] scan_idx_o,
    output logic                          frame_o
);

    localparam int SW = $clog2(NUM_DIGITS);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc_q, presc_d;
    logic [SW-1:0]           scan_q, scan_d;
    logic                    fresh_q, fresh_d;
    logic [4*NUM_DIGITS-1:0] shadow_dig_q, shadow_dig_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [3:0]              cur_dig_q, cur_dig_d;
    logic                    cur_dp_q, cur_dp_d;
    logic                    cur_blank_q, cur_blank_d;
    logic [BRIGHT_W-1:0]     cur_bright_q, cur_bright_d;
    logic [NUM_DIGITS-1:0]   enabled_q, enabled_d;
    logic [6:0]              ag_q, ag_d;
    logic                    dp_q, dp_d;
    logic [SW-1:0]           scan_idx_q, scan_idx_d;
    logic                    frame_q, frame_d;

    logic                    presc_wrap;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lz_vec;
    logic [3:0]              sel_dig;
    logic                    sel_dp;
    logic                    sel_lz;
    logic [63:0]             on_ticks;
    logic [63:0]             presc_wide;
    logic                    in_window;

    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
`ifdef DISP7SEG_HEX_DECODE_EN
            4'd10:   seg = 7'b0001000;
            4'd11:   seg = 7'b0000011;
            4'd12:   seg = 7'b1000110;
            4'd13:   seg = 7'b0100001;
            4'd14:   seg = 7'b0000110;
            4'd15:   seg = 7'b0001110;
`endif
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    always_comb begin
        presc_wrap = (presc_q == PRESC_LAST);
        presc_d    = presc_wrap ? '0 : presc_q + PW'(1);
        scan_d     = scan_q;
        if (presc_wrap) begin
            scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + SW'(1);
        end
        fresh_d      = 1'b0;
        shadow_dig_d = load_i ? digits_i : shadow_dig_q;
        shadow_dp_d  = load_i ? dp_i : shadow_dp_q;

        // A digit is a leading zero when it and every digit above it are zero.
        zero_run = 1'b1;
        lz_vec   = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run & (shadow_dig_q[4*k +: 4] == 4'd0);
            if (k != 0) begin
                lz_vec[k] = zero_run;
            end
        end

        sel_dig = '0;
        sel_dp  = 1'b0;
        sel_lz  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (scan_d == SW'(k)) begin
                sel_dig = shadow_dig_q[4*k +: 4];
                sel_dp  = shadow_dp_q[k];
                sel_lz  = lz_vec[k];
            end
        end

        // Release from reset behaves like a boundary into slot 0 so the
        // first slot gets a freshly sampled brightness.
        cur_dig_d    = cur_dig_q;
        cur_dp_d     = cur_dp_q;
        cur_blank_d  = cur_blank_q;
        cur_bright_d = cur_bright_q;
        if (presc_wrap || fresh_q) begin
            cur_dig_d    = sel_dig;
            cur_dp_d     = sel_dp;
            cur_blank_d  = lz_blank_i & sel_lz;
            cur_bright_d = bright_i;
        end

        on_ticks   = ((64'(cur_bright_q) + 64'd1) * 64'(CLK_DIV)) >> BRIGHT_W;
        presc_wide = 64'(presc_q);
        in_window  = (presc_wide >= 64'(GUARD)) && (presc_wide < on_ticks);

        enabled_d = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((scan_q == SW'(k)) && in_window) begin
                enabled_d[k] = 1'b0;
            end
        end
        ag_d       = cur_blank_q ? 7'b1111111 : seg_decode(cur_dig_q);
        dp_d       = ~cur_dp_q;
        scan_idx_d = scan_q;
        frame_d    = (presc_q == '0) && (scan_q == '0) && !fresh_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            scan_q       <= '0;
            fresh_q      <= 1'b1;
            shadow_dig_q <= '0;
            shadow_dp_q  <= '0;
            cur_dig_q    <= '0;
            cur_dp_q     <= 1'b0;
            cur_blank_q  <= 1'b0;
            cur_bright_q <= '0;
            enabled_q    <= '1;
            ag_q         <= 7'b1111111;
            dp_q         <= 1'b1;
            scan_idx_q   <= '0;
            frame_q      <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            scan_q       <= scan_d;
            fresh_q      <= fresh_d;
            shadow_dig_q <= shadow_dig_d;
            shadow_dp_q  <= shadow_dp_d;
            cur_dig_q    <= cur_dig_d;
            cur_dp_q     <= cur_dp_d;
            cur_blank_q  <= cur_blank_d;
            cur_bright_q <= cur_bright_d;
            enabled_q    <= enabled_d;
            ag_q         <= ag_d;
            dp_q         <= dp_d;
            scan_idx_q   <= scan_idx_d;
            frame_q      <= frame_d;
        end
    end

    assign enabled    = enabled_q;
    assign ag         = ag_q;
    assign dp         = dp_q;
    assign scan_idx_o = scan_idx_q;
    assign frame_o    = frame_q;

endmodule

// File: tb/tb_disp7seg_scan.sv
// Scoreboard bench for disp7seg_scan: stimulus pushes per-slot expectations
// from a reference model; a monitor collects each displayed slot and compares.
module tb_disp7seg_scan;

    localparam int ND = 4;
    localparam int CD = 16;
    localparam int BW = 3;
    localparam int GD = 2;
    localparam int NT = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   digits_i;
    logic [3:0]    dp_i;
    logic          load_i;
    logic [BW-1:0] bright_i;
    logic          lz_blank_i;
    logic [3:0]    enabled;
    logic [6:0]    ag;
    logic          dp;
    logic [1:0]    scan_idx_o;
    logic          frame_o;

    always #5 clk = ~clk;

    disp7seg_scan #(
        .NUM_DIGITS(ND),
        .CLK_DIV   (CD),
        .BRIGHT_W  (BW),
        .GUARD     (GD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digits_i  (digits_i),
        .dp_i      (dp_i),
        .load_i    (load_i),
        .bright_i  (bright_i),
        .lz_blank_i(lz_blank_i),
        .enabled   (enabled),
        .ag        (ag),
        .dp        (dp),
        .scan_idx_o(scan_idx_o),
        .frame_o   (frame_o)
    );

    typedef struct {
        int          idx;
        logic [6:0]  ag;
        logic        dp;
        logic [31:0] mask;
        logic [31:0] fmask;
    } slot_t;

    slot_t      exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    bit         mon_en   = 1'b0;
    logic [6:0] seg_tab [16];

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
`ifdef DISP7SEG_HEX_DECODE_EN
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
        seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
        seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
`else
        for (int v = 10; v < 16; v++) seg_tab[v] = 7'b1111111;
`endif
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: what slot k should look like for a given shadow/config.
    function automatic slot_t model(input logic [15:0] dg, input logic [3:0] dpv,
                                    input bit lz, input int br, input int k);
        slot_t s;
        int    on;
        bit    lead_zero;
        lead_zero = 1'b1;
        for (int j = k; j < ND; j++) if (dg[4*j +: 4] != 4'd0) lead_zero = 1'b0;
        s.idx   = k;
        s.ag    = (lz && k > 0 && lead_zero) ? 7'b1111111 : seg_tab[dg[4*k +: 4]];
        s.dp    = ~dpv[k];
        on      = ((br + 1) * CD) / (1 << BW);
        s.mask  = '0;
        for (int t = GD; t < on && t < CD; t++) s.mask[t] = 1'b1;
        s.fmask = (k == 0) ? 32'd1 : 32'd0;
        return s;
    endfunction

    task automatic applyStimulus(input logic [15:0] dg, input logic [3:0] dpv,
                                 input bit lz, input int br, input int w);
        repeat (w) @(negedge clk);
        #1;
        digits_i   = dg;
        dp_i       = dpv;
        lz_blank_i = lz;
        bright_i   = BW'(br);
        load_i     = 1'b1;
        @(negedge clk);
        load_i     = 1'b0;
    endtask

    // Monitor: one record per displayed slot, compared against the queue.
    initial begin : monitor
        int         cur_idx;
        int         len;
        bit         have;
        bit         stable;
        bit         ghost;
        logic [6:0] ag0;
        logic       dp0;
        logic [31:0] mask;
        logic [31:0] fmask;
        slot_t      e;
        have = 1'b0;
        cur_idx = 0; len = 0; stable = 1'b1; ghost = 1'b0;
        ag0 = '0; dp0 = 1'b0; mask = '0; fmask = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                have = 1'b0;
                continue;
            end
            if (!have || int'(scan_idx_o) != cur_idx) begin
                if (have && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("slot_idx", cur_idx, e.idx);
                    checkOutput("slot_ag", ag0, e.ag);
                    checkOutput("slot_dp", dp0, e.dp);
                    checkOutput("slot_anode_mask", mask, e.mask);
                    checkOutput("slot_frame_mask", fmask, e.fmask);
                    checkOutput("slot_len", len, CD);
                    checkOutput("slot_stable", stable, 1);
                    checkOutput("slot_no_ghost", ghost, 0);
                end
                have    = 1'b1;
                cur_idx = int'(scan_idx_o);
                ag0     = ag;
                dp0     = dp;
                stable  = 1'b1;
                ghost   = 1'b0;
                mask    = '0;
                fmask   = '0;
                len     = 0;
            end
            if (ag !== ag0 || dp !== dp0) stable = 1'b0;
            for (int k = 0; k < ND; k++) if (k != cur_idx && enabled[k] == 1'b0) ghost = 1'b1;
            if (len < 32) begin
                if (enabled[cur_idx] == 1'b0) mask[len] = 1'b1;
                if (frame_o) fmask[len] = 1'b1;
            end
            len++;
        end
    end

    initial begin : stimulus
        logic [15:0] old_dg, new_dg;
        logic [3:0]  old_dp, new_dp;
        bit          old_lz, new_lz;
        int          old_br, new_br, w, n, z;
        bit          ok;

        rst_n = 1'b0; digits_i = 16'h1111; dp_i = 4'hF; load_i = 1'b1;
        bright_i = 3'd7; lz_blank_i = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("rst_enabled", enabled, 4'hF);
        checkOutput("rst_ag", ag, 7'h7F);
        checkOutput("rst_dp", dp, 1);
        checkOutput("rst_scan", scan_idx_o, 0);
        checkOutput("rst_frame", frame_o, 0);
        load_i = 1'b0;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        checkOutput("rel1_enabled", enabled, 4'hF);
        checkOutput("rel1_ag", ag, 7'b1000000);
        @(negedge clk);
        checkOutput("rel2_enabled", enabled, 4'hF);
        checkOutput("rel2_ag_load_ignored", ag, 7'b1000000);
        @(negedge clk);
        checkOutput("rel3_enabled", enabled, 4'hE);

        old_dg = '0; old_dp = '0; old_lz = 1'b0; old_br = 7;
        for (int i = 0; i < NT; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!frame_o && n < 200);
            if (!frame_o) begin
                checkOutput("frame_timeout", 0, 1);
                break;
            end
            #1;
            if (i == 0) exp_q.push_back(model(old_dg, old_dp, old_lz, old_br, 0));
            case (i)
                0: begin new_dg = 16'h4321; new_dp = 4'b0100; new_lz = 1'b0; new_br = 7; end
                1: begin new_dg = 16'h0050; new_dp = 4'b0000; new_lz = 1'b1; new_br = 3; end
                2: begin new_dg = 16'h0000; new_dp = 4'b0000; new_lz = 1'b1; new_br = 0; end
                3: begin new_dg = 16'hA0B7; new_dp = 4'b1001; new_lz = 1'b1; new_br = 5; end
                default: begin
                    new_dg = 16'($urandom);
                    z = $urandom_range(0, 4);
                    for (int j = 4 - z; j < 4; j++) new_dg[4*j +: 4] = 4'd0;
                    new_dp = 4'($urandom);
                    new_lz = 1'($urandom_range(0, 1));
                    new_br = $urandom_range(0, 7);
                end
            endcase
            w = (i % 4 == 3) ? CD - 2 : $urandom_range(0, CD - 2);
            applyStimulus(new_dg, new_dp, new_lz, new_br, w);
            // A load on the boundary edge itself reaches slot 1 one slot late.
            if (w == CD - 2) exp_q.push_back(model(old_dg, old_dp, new_lz, new_br, 1));
            else             exp_q.push_back(model(new_dg, new_dp, new_lz, new_br, 1));
            exp_q.push_back(model(new_dg, new_dp, new_lz, new_br, 2));
            exp_q.push_back(model(new_dg, new_dp, new_lz, new_br, 3));
            exp_q.push_back(model(new_dg, new_dp, new_lz, new_br, 0));
            old_dg = new_dg; old_dp = new_dp; old_lz = new_lz; old_br = new_br;
        end

        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        // Mid-slot asynchronous reset with a non-zero shadow loaded.
        @(negedge clk);
        #1;
        digits_i = 16'h8888; dp_i = 4'hF; lz_blank_i = 1'b0; bright_i = 3'd7; load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            n++;
            if (scan_idx_o == 2'd1) ok = 1'b1;
        end
        ok = 1'b0;
        while (!ok && n < 400) begin
            @(negedge clk);
            n++;
            if (scan_idx_o == 2'd2) ok = 1'b1;
        end
        checkOutput("slot2_reached", ok, 1);
        repeat (5) @(negedge clk);
        checkOutput("pre_async_ag", ag, 7'b0000000);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        checkOutput("async_enabled", enabled, 4'hF);
        checkOutput("async_ag", ag, 7'h7F);
        checkOutput("async_dp", dp, 1);
        checkOutput("async_scan", scan_idx_o, 0);
        checkOutput("async_frame", frame_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("post_async_ag", ag, 7'b1000000);
        checkOutput("post_async_dp", dp, 1);
        checkOutput("post_async_scan", scan_idx_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
